// File: rtl/dm_pkg.sv
// Debug-module types shared by the DTM-side DMI controller: request/response
// structs, the DTM op and error encodings, and the controller state type.
package dm;

    localparam int DmiDrWidth = 41;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_t;

    typedef enum logic [1:0] {
        DMINoError  = 2'h0,
        DMIReserved = 2'h1,
        DMIOPFailed = 2'h2,
        DMIBusy     = 2'h3
    } dtm_err_t;

    typedef enum logic [1:0] {
        Idle,
        Req,
        WaitResp,
        Drain
    } dmi_ctrl_state_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_t     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_access_ctrl.sv
// DMI transaction controller: turns DTM DR updates into DM request/response
// handshakes, tracks the sticky DTM error and builds the DR capture word.
module dmi_access_ctrl
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        update_i,
    input  logic [6:0]  upd_addr_i,
    input  logic [1:0]  upd_op_i,
    input  logic [31:0] upd_data_i,
    input  logic        capture_i,
    input  logic        dmireset_i,
    input  logic        dmihardreset_i,
    output logic [40:0] capture_word_o,
    output logic [1:0]  error_o,
    output logic        busy_o,
    output logic        dmi_req_valid_o,
    output logic [40:0] dmi_req_o,
    input  logic        dmi_req_ready_i,
    input  logic        dmi_resp_valid_i,
    input  logic [33:0] dmi_resp_i,
    output logic        dmi_resp_ready_o
);

    // A disabled timeout still needs a one-bit counter to stay legal.
    localparam int unsigned CntW = (CntWidth > 0) ? CntWidth : 1;

    dmi_ctrl_state_e state_q;
    dmi_req_t        req_q;
    dtm_err_t        error_q;
    dtm_err_t        err_d;
    dtm_err_t        new_err;
    logic [31:0]     rdata_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     cnt_ext;
    logic [40:0]     capture_word_q;
    logic            req_valid_q;
    logic            resp_ready_q;
    logic            busy_q;
    dmi_resp_t       resp;
    logic            accept_upd;
    logic            req_hs;
    logic            resp_hs;
    logic            timeout;
    logic            raise_busy;
    logic            raise_fail;

    assign resp    = dmi_resp_i;
    assign cnt_ext = 32'(cnt_q);

    always_comb begin
        accept_upd = 1'b0;
        req_hs     = 1'b0;
        resp_hs    = 1'b0;
        timeout    = 1'b0;
        raise_busy = 1'b0;
        raise_fail = 1'b0;
        new_err    = DMINoError;
        err_d      = error_q;

        accept_upd = (state_q == Idle) && update_i && (error_q == DMINoError) &&
                     ((upd_op_i == DTM_READ) || (upd_op_i == DTM_WRITE));
        req_hs     = (state_q == Req) && dmi_req_ready_i;
        resp_hs    = (state_q == WaitResp) && dmi_resp_valid_i;

        // A handshake in the same cycle as the last allowed wait cycle wins.
        if ((TimeoutCycles != 0) && (cnt_ext + 32'd1 == TimeoutCycles)) begin
            timeout = ((state_q == Req) && !req_hs) || ((state_q == WaitResp) && !resp_hs);
        end

        raise_busy = (state_q != Idle) && (update_i || capture_i);
        raise_fail = timeout || (resp_hs && (resp.resp != DTM_SUCCESS));

        if (raise_busy) begin
            new_err = DMIBusy;
        end else if (raise_fail) begin
            new_err = DMIOPFailed;
        end

        // Sticky error: only dmireset may replace it, and a new error beats the clear.
        if ((error_q == DMINoError) || dmireset_i) begin
            err_d = new_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || dmihardreset_i) begin
            state_q        <= Idle;
            req_q          <= '0;
            error_q        <= DMINoError;
            rdata_q        <= '0;
            cnt_q          <= '0;
            capture_word_q <= '0;
            req_valid_q    <= 1'b0;
            resp_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            error_q <= err_d;
            if (capture_i) begin
                capture_word_q <= {req_q.addr, rdata_q, err_d};
            end

            unique case (state_q)
                Idle: begin
                    if (accept_upd) begin
                        req_q.addr  <= upd_addr_i;
                        req_q.op    <= dtm_op_t'(upd_op_i);
                        req_q.data  <= upd_data_i;
                        cnt_q       <= '0;
                        state_q     <= Req;
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                Req: begin
                    if (req_hs) begin
                        state_q      <= WaitResp;
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                        cnt_q        <= '0;
                    end else if (timeout) begin
                        state_q     <= Idle;
                        req_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (TimeoutCycles != 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WaitResp: begin
                    if (resp_hs) begin
                        state_q      <= Idle;
                        resp_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        if (req_q.op == DTM_READ) begin
                            rdata_q <= resp.data;
                        end
                    end else if (timeout) begin
                        state_q <= Drain;
                    end else if (TimeoutCycles != 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                Drain: begin
                    // The late response belongs to an op already reported as failed.
                    if (dmi_resp_valid_i) begin
                        state_q      <= Idle;
                        resp_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

    assign capture_word_o   = capture_word_q;
    assign error_o          = error_q;
    assign busy_o           = busy_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_o        = req_q;
    assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Bench for dmi_access_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of error, address and read data.
module tb_dmi_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        update_i = 1'b0;
    logic [6:0]  upd_addr_i = '0;
    logic [1:0]  upd_op_i = '0;
    logic [31:0] upd_data_i = '0;
    logic        capture_i = 1'b0;
    logic        dmireset_i = 1'b0;
    logic        dmihardreset_i = 1'b0;
    logic [40:0] capture_word_o;
    logic [1:0]  error_o;
    logic        busy_o;
    logic        dmi_req_valid_o;
    logic [40:0] dmi_req_o;
    logic        dmi_req_ready_i = 1'b0;
    logic        dmi_resp_valid_i = 1'b0;
    logic [33:0] dmi_resp_i = '0;
    logic        dmi_resp_ready_o;

    int checks = 0;
    int passes = 0;

    logic [1:0]  m_err = 2'd0;
    logic [6:0]  m_addr = 7'd0;
    logic [31:0] m_rdata = 32'd0;

    always #5 clk = ~clk;

    dmi_access_ctrl #(.TimeoutCycles(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .update_i         (update_i),
        .upd_addr_i       (upd_addr_i),
        .upd_op_i         (upd_op_i),
        .upd_data_i       (upd_data_i),
        .capture_i        (capture_i),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .capture_word_o   (capture_word_o),
        .error_o          (error_o),
        .busy_o           (busy_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_ready_o (dmi_resp_ready_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One DR update followed, if accepted, by a full request/response exchange.
    task automatic do_txn(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                          input int req_dly, input int resp_dly,
                          input logic [1:0] code, input logic [31:0] rd);
        logic        accept;
        logic [40:0] exp_req;
        accept  = (m_err == 2'd0) && (op == 2'd1 || op == 2'd2);
        exp_req = {a, op, d};
        update_i = 1'b1; upd_addr_i = a; upd_op_i = op; upd_data_i = d;
        step();
        update_i = 1'b0;
        if (!accept) begin
            checks++;
            if ({dmi_req_valid_o, busy_o, error_o} !== {2'b00, m_err})
                $display("FAIL ignored_update: got v=%b b=%b e=%0d want v=0 b=0 e=%0d",
                         dmi_req_valid_o, busy_o, error_o, m_err);
            else passes++;
            return;
        end
        m_addr = a;
        for (int i = 0; i <= req_dly; i++) begin
            checks++;
            if ({dmi_req_valid_o, dmi_req_o} !== {1'b1, exp_req})
                $display("FAIL req_payload: got v=%b req=%h want v=1 req=%h",
                         dmi_req_valid_o, dmi_req_o, exp_req);
            else passes++;
            dmi_req_ready_i = (i == req_dly);
            step();
        end
        dmi_req_ready_i = 1'b0;
        for (int i = 0; i <= resp_dly; i++) begin
            checks++;
            if ({dmi_req_valid_o, dmi_resp_ready_o, busy_o} !== 3'b011)
                $display("FAIL wait_resp: got v=%b rr=%b b=%b want 0 1 1",
                         dmi_req_valid_o, dmi_resp_ready_o, busy_o);
            else passes++;
            if (i == resp_dly) begin
                dmi_resp_valid_i = 1'b1;
                dmi_resp_i = {rd, code};
            end
            step();
        end
        dmi_resp_valid_i = 1'b0;
        if (op == 2'd1) m_rdata = rd;
        if (code != 2'd0 && m_err == 2'd0) m_err = 2'd2;
        checks++;
        if ({busy_o, dmi_resp_ready_o, dmi_req_valid_o, error_o} !== {3'b000, m_err})
            $display("FAIL txn_done: got b=%b rr=%b v=%b e=%0d want 0 0 0 e=%0d",
                     busy_o, dmi_resp_ready_o, dmi_req_valid_o, error_o, m_err);
        else passes++;
    endtask

    task automatic do_capture();
        capture_i = 1'b1;
        step();
        capture_i = 1'b0;
        checks++;
        if (capture_word_o !== {m_addr, m_rdata, m_err})
            $display("FAIL capture: got %h want %h", capture_word_o, {m_addr, m_rdata, m_err});
        else passes++;
    endtask

    task automatic do_dmireset();
        dmireset_i = 1'b1;
        step();
        dmireset_i = 1'b0;
        m_err = 2'd0;
        checks++;
        if (error_o !== 2'd0) $display("FAIL dmireset: got %0d want 0", error_o);
        else passes++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        checks++;
        if ({dmi_req_valid_o, dmi_resp_ready_o, busy_o, error_o, capture_word_o} !== 46'd0)
            $display("FAIL reset_state: got v=%b rr=%b b=%b e=%0d cw=%h want all zero",
                     dmi_req_valid_o, dmi_resp_ready_o, busy_o, error_o, capture_word_o);
        else passes++;
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_read();
        do_txn(7'h11, 2'd1, 32'h0, 0, 1, 2'd0, 32'h0040_0C82);
        do_capture();
    endtask

    task automatic test_write_stall();
        do_txn(7'h10, 2'd2, 32'h8000_0001, 3, 0, 2'd0, 32'hFFFF_FFFF);
        do_capture();
    endtask

    task automatic test_busy();
        update_i = 1'b1; upd_addr_i = 7'h22; upd_op_i = 2'd1; upd_data_i = 32'h0;
        step();
        update_i = 1'b0;
        dmi_req_ready_i = 1'b1;
        step();
        dmi_req_ready_i = 1'b0;
        m_addr = 7'h22;
        update_i = 1'b1; upd_addr_i = 7'h33; upd_op_i = 2'd2; upd_data_i = 32'h5555_AAAA;
        step();
        update_i = 1'b0;
        m_err = 2'd3;
        checks++;
        if ({error_o, busy_o, dmi_req_valid_o} !== {2'd3, 2'b10})
            $display("FAIL busy_update: got e=%0d b=%b v=%b want e=3 b=1 v=0",
                     error_o, busy_o, dmi_req_valid_o);
        else passes++;
        dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'hCAFE_0001, 2'd0};
        step();
        dmi_resp_valid_i = 1'b0;
        m_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dmi_req_valid_o, busy_o, error_o} !== {2'b00, 2'd3})
                $display("FAIL second_not_issued: got v=%b b=%b e=%0d want 0 0 3",
                         dmi_req_valid_o, busy_o, error_o);
            else passes++;
            step();
        end
        do_txn(7'h44, 2'd2, 32'h1234_0000, 0, 0, 2'd0, 32'h0);
        do_capture();
        do_dmireset();
        do_txn(7'h44, 2'd2, 32'h1234_0000, 1, 0, 2'd0, 32'h0);
        update_i = 1'b1; upd_addr_i = 7'h55; upd_op_i = 2'd1; upd_data_i = 32'h0;
        step();
        update_i = 1'b0;
        m_addr = 7'h55;
        capture_i = 1'b1; dmi_req_ready_i = 1'b1;
        step();
        capture_i = 1'b0; dmi_req_ready_i = 1'b0;
        m_err = 2'd3;
        checks++;
        if (capture_word_o !== {7'h55, m_rdata, 2'd3})
            $display("FAIL busy_capture: got %h want %h", capture_word_o, {7'h55, m_rdata, 2'd3});
        else passes++;
        dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0BAD_F00D, 2'd0};
        step();
        dmi_resp_valid_i = 1'b0;
        m_rdata = 32'h0BAD_F00D;
        do_dmireset();
    endtask

    task automatic test_timeout();
        update_i = 1'b1; upd_addr_i = 7'h0A; upd_op_i = 2'd1; upd_data_i = 32'h0;
        step();
        update_i = 1'b0;
        m_addr = 7'h0A;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({dmi_req_valid_o, error_o} !== 3'b100)
                $display("FAIL req_wait[%0d]: got v=%b e=%0d want v=1 e=0", i, dmi_req_valid_o, error_o);
            else passes++;
            step();
        end
        m_err = 2'd2;
        checks++;
        if ({dmi_req_valid_o, busy_o, error_o} !== 4'b0010)
            $display("FAIL req_timeout: got v=%b b=%b e=%0d want 0 0 2", dmi_req_valid_o, busy_o, error_o);
        else passes++;
        do_dmireset();

        update_i = 1'b1; upd_addr_i = 7'h0B; upd_op_i = 2'd1; upd_data_i = 32'h0;
        step();
        update_i = 1'b0;
        m_addr = 7'h0B;
        dmi_req_ready_i = 1'b1;
        step();
        dmi_req_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({dmi_resp_ready_o, busy_o, error_o} !== 4'b1100)
                $display("FAIL resp_wait[%0d]: got rr=%b b=%b e=%0d want 1 1 0",
                         i, dmi_resp_ready_o, busy_o, error_o);
            else passes++;
            step();
        end
        m_err = 2'd2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dmi_resp_ready_o, busy_o, error_o} !== 4'b1110)
                $display("FAIL drain[%0d]: got rr=%b b=%b e=%0d want 1 1 2",
                         i, dmi_resp_ready_o, busy_o, error_o);
            else passes++;
            step();
        end
        dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'hDEAD_BEEF, 2'd0};
        step();
        dmi_resp_valid_i = 1'b0;
        checks++;
        if ({dmi_resp_ready_o, busy_o, error_o} !== 4'b0010)
            $display("FAIL drain_done: got rr=%b b=%b e=%0d want 0 0 2", dmi_resp_ready_o, busy_o, error_o);
        else passes++;
        do_capture();
        do_dmireset();
    endtask

    task automatic test_resp_error();
        do_txn(7'h05, 2'd1, 32'h0, 0, 1, 2'd2, 32'h1234_5678);
        do_capture();
        do_dmireset();
        update_i = 1'b1; upd_addr_i = 7'h06; upd_op_i = 2'd1; upd_data_i = 32'h0;
        step();
        update_i = 1'b0;
        m_addr = 7'h06;
        dmi_req_ready_i = 1'b1;
        step();
        dmi_req_ready_i = 1'b0;
        dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h9999_0000, 2'd2}; dmireset_i = 1'b1;
        step();
        dmi_resp_valid_i = 1'b0; dmireset_i = 1'b0;
        m_err = 2'd2;
        m_rdata = 32'h9999_0000;
        checks++;
        if ({error_o, busy_o} !== 3'b100)
            $display("FAIL reset_vs_error: got e=%0d b=%b want e=2 b=0", error_o, busy_o);
        else passes++;
        do_capture();
        do_dmireset();
    endtask

    task automatic test_hardreset();
        update_i = 1'b1; upd_addr_i = 7'h10; upd_op_i = 2'd2; upd_data_i = 32'h7777_7777;
        step();
        update_i = 1'b0;
        checks++;
        if (dmi_req_valid_o !== 1'b1) $display("FAIL hard_pre: got v=%b want 1", dmi_req_valid_o);
        else passes++;
        dmihardreset_i = 1'b1;
        step();
        dmihardreset_i = 1'b0;
        m_err = 2'd0; m_addr = 7'd0; m_rdata = 32'd0;
        checks++;
        if ({dmi_req_valid_o, dmi_resp_ready_o, busy_o, error_o, capture_word_o} !== 46'd0)
            $display("FAIL hardreset: got v=%b rr=%b b=%b e=%0d cw=%h want all zero",
                     dmi_req_valid_o, dmi_resp_ready_o, busy_o, error_o, capture_word_o);
        else passes++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int unsigned r;
            logic [1:0]  op;
            logic [1:0]  code;
            r = $urandom_range(0, 9);
            op = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
            code = ($urandom_range(0, 6) == 0) ? 2'd2 : 2'd0;
            do_txn(7'($urandom), op, $urandom, int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 5)), code, $urandom);
            if ($urandom_range(0, 2) == 0) do_capture();
            if (m_err != 2'd0 && $urandom_range(0, 1) == 1) do_dmireset();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_busy();
        test_timeout();
        test_resp_error();
        test_hardreset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
